// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM load sequencer.
//   state_t   : sequencer FSM states
//   IDX_ROM   : ioctl_index of the ROM image download
//   IDX_DIP   : ioctl_index of the DIP switch download
//   DIP_BYTES : number of DIP switch bytes kept
package rom_load_pkg;

    typedef enum logic [1:0] {
        WAIT_ROM = 2'd0,
        LOAD     = 2'd1,
        SETTLE   = 2'd2,
        RUN      = 2'd3
    } state_t;

    localparam logic [7:0] IDX_ROM   = 8'd0;
    localparam logic [7:0] IDX_DIP   = 8'd254;
    localparam int         DIP_BYTES = 3;

endpackage

// File: rtl/rom_port_arb.sv
// Shared ROM port arbiter: download writes win over the single-beat read
// requester, and at most one read is outstanding.
//   clk_sys, reset_n   : clock, synchronous active-low reset
//   wr_req/addr/data   : write to issue on the port next cycle
//   rd_allow           : FSM permits reads this cycle
//   rq_req/rq_addr     : level read request (held until rq_ack)
//   rq_ack/rq_data     : one-cycle ack, data valid with it
//   mem_*              : registered shared ROM port; mem_dout is read data
module rom_port_arb #(
    parameter int ADDR_W = 17
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_allow,
    input  logic              rq_req,
    input  logic [ADDR_W-1:0] rq_addr,
    output logic              rq_ack,
    output logic [7:0]        rq_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_dout
);
    import rom_load_pkg::*;

    // vld_pipe[0]: read on the port this cycle, vld_pipe[1]: data returning
    logic [1:0] vld_pipe;
    logic       grant;
    logic [7:0] data_q;

    // Only the cycle carrying mem_re blocks a new grant. The ack cycle is
    // free, so a requester that keeps rq_req high through its ack cycle
    // (with a new address) gets one ack every 2 cycles; one that is done
    // must drop rq_req within its ack cycle.
    assign grant = rq_req && rd_allow && !wr_req && !vld_pipe[0];

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            data_q   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], grant};
            mem_we   <= wr_req;
            if (wr_req) begin
                mem_addr <= wr_addr;
                mem_din  <= wr_data;
            end else if (grant) begin
                mem_addr <= rq_addr;
            end
            if (vld_pipe[1])
                data_q <= mem_dout;
        end
    end

    assign mem_re  = vld_pipe[0];
    assign rq_ack  = vld_pipe[1];
    // The BRAM presents data the cycle after mem_re, which is the ack cycle;
    // pass it straight through then and hold it afterwards.
    assign rq_data = vld_pipe[1] ? mem_dout : data_q;

endmodule

// File: rtl/rom_load_sequencer.sv
// Sequences the ioctl download stream into the shared ROM port and the DIP
// switch bytes, and holds the game core in reset until a complete ROM image
// of exactly ROM_BYTES has been loaded.
//   clk_sys, reset_n          : clock, synchronous active-low reset
//   ioctl_download/index/wr/addr/dout : hps_io download stream
//   mem_addr/din/we/re, mem_dout      : shared ROM port
//   rq_req/rq_addr, rq_ack/rq_data    : single-beat read requester
//   dip_sw      : {sw2,sw1,sw0}
//   core_reset  : game core reset, high until RUN
//   dl_busy     : ROM load in progress
//   dl_error    : last ROM load had the wrong length
module rom_load_sequencer #(
    parameter int ADDR_W    = 17,
    parameter int ROM_BYTES = 86016,
    parameter int HOLD_CYC  = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_dout,
    input  logic              rq_req,
    input  logic [ADDR_W-1:0] rq_addr,
    output logic              rq_ack,
    output logic [7:0]        rq_data,
    output logic [23:0]       dip_sw,
    output logic              core_reset,
    output logic              dl_busy,
    output logic              dl_error
);
    import rom_load_pkg::*;

    localparam int          HOLD_W  = $clog2(HOLD_CYC + 1);
    localparam logic [24:0] ROM_LEN = 25'(ROM_BYTES);

    state_t                      state_q, state_d;
    logic [24:0]                 cnt_q;
    logic [HOLD_W-1:0]           hold_q;
    logic                        dl_error_q;
    logic [DIP_BYTES-1:0][7:0]   dip_q;

    logic start_load, rom_wr, rom_hit, dip_wr, rd_allow;
    logic enter_load, load_ok, load_bad;

    assign start_load = ioctl_download && (ioctl_index == IDX_ROM);
    // Every ROM byte counts toward the length check; only in-range ones
    // reach the port.
    assign rom_wr     = (state_q == LOAD) && ioctl_wr && (ioctl_index == IDX_ROM);
    assign rom_hit    = rom_wr && (ioctl_addr < ROM_LEN);
    assign dip_wr     = ioctl_wr && (ioctl_index == IDX_DIP) &&
                        (ioctl_addr < 25'(DIP_BYTES));

    assign enter_load = (state_q != LOAD) && (state_d == LOAD);
    assign load_ok    = (state_q == LOAD) && (state_d == SETTLE);
    assign load_bad   = (state_q == LOAD) && (state_d == WAIT_ROM);

    always_comb begin
        state_d    = state_q;
        core_reset = 1'b1;
        dl_busy    = 1'b0;
        rd_allow   = 1'b0;
        case (state_q)
            WAIT_ROM: begin
                rd_allow = 1'b1;
                if (start_load)
                    state_d = LOAD;
            end
            LOAD: begin
                dl_busy = 1'b1;
                // Entered with ioctl_download high, so low here is the
                // falling edge of the download window.
                if (!ioctl_download)
                    state_d = (cnt_q == ROM_LEN) ? SETTLE : WAIT_ROM;
            end
            SETTLE: begin
                if (hold_q == '0)
                    state_d = RUN;
            end
            RUN: begin
                core_reset = 1'b0;
                rd_allow   = 1'b1;
                if (start_load)
                    state_d = LOAD;
            end
            default: state_d = WAIT_ROM;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= WAIT_ROM;
            cnt_q      <= '0;
            hold_q     <= '0;
            dl_error_q <= 1'b0;
            dip_q      <= '0;
        end else begin
            state_q <= state_d;

            if (enter_load)
                cnt_q <= '0;
            else if (rom_wr && (cnt_q != '1))
                cnt_q <= cnt_q + 25'd1;

            if (enter_load)
                dl_error_q <= 1'b0;
            else if (load_bad)
                dl_error_q <= 1'b1;

            // Loaded with HOLD_CYC-1 so SETTLE lasts exactly HOLD_CYC cycles.
            if (load_ok)
                hold_q <= HOLD_W'(HOLD_CYC - 1);
            else if ((state_q == SETTLE) && (hold_q != '0))
                hold_q <= hold_q - 1'b1;

            if (dip_wr)
                dip_q[ioctl_addr[1:0]] <= ioctl_dout;
        end
    end

    assign dip_sw   = dip_q;
    assign dl_error = dl_error_q;

    rom_port_arb #(.ADDR_W(ADDR_W)) u_arb (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .wr_req   (rom_hit),
        .wr_addr  (ioctl_addr[ADDR_W-1:0]),
        .wr_data  (ioctl_dout),
        .rd_allow (rd_allow),
        .rq_req   (rq_req),
        .rq_addr  (rq_addr),
        .rq_ack   (rq_ack),
        .rq_data  (rq_data),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_re   (mem_re),
        .mem_dout (mem_dout)
    );

endmodule
